// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game: state encoding, digit codes, LFSR setup.
// Pure declarations; no latency or backpressure of its own.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FOUL
  } state_t;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] EIGHT     = 4'd8;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else if (v[3]) return 2'd3;
    else           return 2'd0;
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Player-side signal bundle: tick/switches/buttons in, digits and lamps out.
// No handshake; all signals are level or single-cycle pulses.
interface reaction_game_ctrl_if;
  logic       tick;
  logic [3:0] dsws;
  logic [3:0] btns;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       go;
  logic       foul;
  logic [1:0] winner;

  modport master (
    output tick, dsws, btns,
    input  tens, ones, go, foul, winner
  );

  modport slave (
    input  tick, dsws, btns,
    output tens, ones, go, foul, winner
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter saturating at 99; clr beats hold beats inc.
// Count updates on the clock edge after inc; next value is exported for registered displays.
module bcd2_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       hold,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tens_nxt,
  output logic [3:0] ones_nxt
);

  always_comb begin
    tens_nxt = tens;
    ones_nxt = ones;
    if (clr) begin
      tens_nxt = 4'd0;
      ones_nxt = 4'd0;
    end else if (!hold && inc && !(tens == 4'd9 && ones == 4'd9)) begin
      if (ones == 4'd9) begin
        ones_nxt = 4'd0;
        tens_nxt = tens + 4'd1;
      end else begin
        ones_nxt = ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else begin
      tens <= tens_nxt;
      ones <= ones_nxt;
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction game: arm when all players hold, random wait, then time the first release in tenths.
// Every output is registered and moves one cycle after the causing input/tick; no backpressure.
module reaction_game_ctrl
  import game_pkg::*;
#(
  parameter int MIN_WAIT  = 10,
  parameter int RAND_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reaction_game_ctrl_if.slave  io
);

  localparam int WAIT_MAX = MIN_WAIT + (1 << RAND_BITS) - 1;
  localparam int WCW      = $clog2(WAIT_MAX + 1);

  state_t         state, next_state;
  logic [7:0]     lfsr;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

  logic       all_held, abort;
  logic [3:0] rel;

  logic       cnt_clr, cnt_inc, cnt_hold, at_99;
  logic [3:0] cnt_tens, cnt_ones, cnt_tens_nxt, cnt_ones_nxt;

  logic [3:0] tens_q, ones_q, tens_d, ones_d;
  logic       go_q, foul_q, go_d, foul_d;
  logic [1:0] winner_q, winner_d;

  assign all_held = (io.dsws != 4'd0) && ((io.btns & io.dsws) == io.dsws);
  assign rel      = io.dsws & ~io.btns;
  assign abort    = (io.dsws == 4'd0);
  assign at_99    = (cnt_tens == 4'd9) && (cnt_ones == 4'd9);

  bcd2_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .hold     (cnt_hold),
    .tens     (cnt_tens),
    .ones     (cnt_ones),
    .tens_nxt (cnt_tens_nxt),
    .ones_nxt (cnt_ones_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lfsr     <= LFSR_SEED;
      wait_cnt <= '0;
      tens_q   <= BLANK;
      ones_q   <= BLANK;
      go_q     <= 1'b0;
      foul_q   <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      state    <= next_state;
      lfsr     <= lfsr_step(lfsr);
      wait_cnt <= wait_cnt_nxt;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      go_q     <= go_d;
      foul_q   <= foul_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    next_state   = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (all_held) next_state = S_ARMED;
      end
      S_ARMED: begin
        if (!all_held) begin
          next_state = S_IDLE;
        end else if (io.tick) begin
          next_state   = S_WAIT;
          wait_cnt_nxt = WCW'(MIN_WAIT) + WCW'(lfsr[RAND_BITS-1:0]);
        end
      end
      S_WAIT: begin
        // An early release is a foul even when the wait expires in the same cycle.
        if (abort) begin
          next_state = S_IDLE;
        end else if (rel != 4'd0) begin
          next_state = S_FOUL;
        end else if (io.tick) begin
          if (wait_cnt <= WCW'(1)) begin
            next_state   = S_GO;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt - WCW'(1);
          end
        end
      end
      S_GO: begin
        if (abort)                   next_state = S_IDLE;
        else if (rel != 4'd0)        next_state = S_DONE;
        else if (io.tick && at_99)   next_state = S_DONE;
      end
      S_DONE, S_FOUL: begin
        if (abort) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = !(state == S_GO || state == S_DONE);
    cnt_hold = (state == S_DONE) || (state == S_GO && rel != 4'd0);
    cnt_inc  = (state == S_GO) && io.tick && !abort;

    go_d     = (next_state == S_GO);
    foul_d   = (next_state == S_FOUL);
    winner_d = winner_q;
    if (state == S_GO && next_state == S_DONE)
      winner_d = (rel != 4'd0) ? lowest_idx(rel) : 2'd0;
    else if (next_state == S_ARMED)
      winner_d = 2'd0;

    // Digits are driven from the next state so they change together with go/foul.
    case (next_state)
      S_IDLE:          begin tens_d = BLANK;        ones_d = BLANK;        end
      S_ARMED, S_WAIT: begin tens_d = 4'd0;         ones_d = 4'd0;         end
      S_GO, S_DONE:    begin tens_d = cnt_tens_nxt; ones_d = cnt_ones_nxt; end
      S_FOUL:          begin tens_d = EIGHT;        ones_d = EIGHT;        end
      default:         begin tens_d = BLANK;        ones_d = BLANK;        end
    endcase
  end

  assign io.tens   = tens_q;
  assign io.ones   = ones_q;
  assign io.go     = go_q;
  assign io.foul   = foul_q;
  assign io.winner = winner_q;

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 10, the minimum WAIT length in tenths ticks.
REQ-002 SHALL have parameter RAND_BITS, default 5, the number of LFSR bits added to MIN_WAIT.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-004 SHALL have port rst_n  input  1  reset; it is synchronous and active-low.
REQ-005 SHALL have port tick  input  1  one-cycle pulse every 0.1 s, driven from the tenths divider.
REQ-006 SHALL have port dsws  input  4  player-enable switches; bit i set means player i is in the game.
REQ-007 SHALL have port btns  input  4  player buttons; 1 means pressed.
REQ-008 SHALL have port tens  output  4  BCD tens digit; 4'hF means blank.
REQ-009 SHALL have port ones  output  4  BCD ones digit; 4'hF means blank.
REQ-010 SHALL have port go  output  1  GO lamp; high only in state GO.
REQ-011 SHALL have port foul  output  1  high in state FOUL.
REQ-012 SHALL have port winner  output  2  index of the winning player; valid in DONE.

Function
REQ-013 SHALL define all_held as (dsws != 0) and ((btns & dsws) == dsws), and rel as dsws & ~btns.
REQ-014 SHALL implement the states IDLE, ARMED, WAIT, GO, DONE and FOUL.
REQ-015 IDLE: blank both digits; on all_held, go to ARMED.
REQ-016 ARMED: show 0 and 0; on all_held low, go to IDLE; on tick with all_held high, load wait_cnt = MIN_WAIT + lfsr[RAND_BITS-1:0] and go to WAIT.
REQ-017 WAIT: keep the digits at 0 and 0; each tick decrements wait_cnt; on a tick when wait_cnt == 1, go to GO with go=1 on the next cycle.
REQ-018 WAIT: if rel != 0, go to FOUL; this takes priority over the tick expiry in the same cycle.
REQ-019 GO: each tick increments the two-digit BCD count (ones 9 -> 0 with carry into tens).
REQ-020 GO: on the first cycle with rel != 0, latch winner = lowest set index of rel, freeze the count, and go to DONE.
REQ-021 GO: if release and tick occur in the same cycle, the release wins and the count does not include that tick.
REQ-022 GO: on a tick when the count is 99, hold 99, set winner=0, and go to DONE (timeout).
REQ-023 DONE: hold the digits and winner, with go=0; when dsws == 0, go to IDLE.
REQ-024 FOUL: foul=1 and both digits show 8; when dsws == 0, go to IDLE.
REQ-025 SHALL treat dsws == 0 in ARMED, WAIT or GO as an abort and go to IDLE the next cycle.
REQ-026 SHALL run the LFSR freely every clk cycle: 8-bit Galois, taps x^8+x^6+x^5+x^4+1.
REQ-027 SHALL make all outputs registered; each output changes one cycle after the triggering input or tick.
REQ-028 SHALL size wait_cnt to MIN_WAIT + 2^RAND_BITS - 1 with no overflow.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, set: state IDLE, tens=ones=4'hF, go=0, foul=0, winner=0, lfsr=8'h01, wait_cnt=0, count=00.
REQ-030 SHALL let reset override any state mid-round; no partial result survives reset.

Structure
REQ-031 SHALL place the state enum, the BLANK=4'hF constant, LFSR_SEED and LFSR_TAPS in shared package game_pkg.
REQ-032 SHALL put the BCD count in sub-module bcd2_counter with inputs clr, inc, hold; outputs tens and ones; saturating at 99.
REQ-033 SHALL contain no derived clocks; tick is used only as an enable.

Verification
REQ-034 Reset test: hold rst_n=0 for 2 cycles -> tens=ones=F, go=0, foul=0, winner=0.
REQ-035 Normal round: MIN_WAIT=2, RAND_BITS=1, dsws=4'b0011 with btns=4'b0011; tick until go=1; 23 ticks; release btns[1] -> DONE, tens=2, ones=3, winner=1.
REQ-036 Simultaneous release in GO: count=05, then btns 0 and 2 released in the same cycle as a tick -> winner=0 and count=05.
REQ-037 Foul: release btns[0] in WAIT in the same cycle as expiry -> foul=1, digits 8/8, go never asserted; dsws=0 -> IDLE with digits blank.
REQ-038 Timeout: no release for 99 ticks of GO -> digits 9/9 held, winner=0; one more tick -> unchanged.
REQ-039 Abort and reset: dsws=0 in WAIT -> IDLE next cycle; rst_n=0 in GO with count=42 -> reset values the next cycle.
